forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 104 ++++++++++
 tb/tb_forward_scoreboard.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Tracks the destinations of in-flight post-EX instructions and selects bypass sources and load-use stalls.
// Optional stall counter port stall_cnt is enabled with macro FWD_STALL_CNT_EN.
module forward_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic              flush,
    output logic [SEL_W-1:0]  fwd_rs,
    output logic [SEL_W-1:0]  fwd_rt,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              stall
);

    logic              valid_reg [DEPTH];
    logic              we_reg    [DEPTH];
    logic              load_reg  [DEPTH];
    logic [ADDR_W-1:0] rd_reg    [DEPTH];

    logic [DEPTH-1:0] rs_match;
    logic [DEPTH-1:0] rt_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            // Register 0 is hard-wired, so it never matches any entry.
            assign rs_match[gi] = valid_reg[gi] && we_reg[gi] && (rd_reg[gi] == ex_rs) && (ex_rs != '0);
            assign rt_match[gi] = valid_reg[gi] && we_reg[gi] && (rd_reg[gi] == ex_rt) && (ex_rt != '0);
        end
    endgenerate

    logic [SEL_W-1:0] sel_rs_next;
    logic [SEL_W-1:0] sel_rt_next;
    logic             rs_load_hazard;
    logic             rt_load_hazard;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel_rs_next    = '0;
        sel_rt_next    = '0;
        rs_load_hazard = 1'b0;
        rt_load_hazard = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rs_match[i]) begin
                sel_rs_next    = SEL_W'(i + 1);
                rs_load_hazard = load_reg[i] && (i < LOAD_LAT);
            end
            if (rt_match[i]) begin
                sel_rt_next    = SEL_W'(i + 1);
                rt_load_hazard = load_reg[i] && (i < LOAD_LAT);
            end
        end
    end

    assign fwd_rs = ex_valid ? sel_rs_next : '0;
    assign fwd_rt = ex_valid ? sel_rt_next : '0;
    assign stall  = ex_valid && (rs_load_hazard || rt_load_hazard);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else begin
            // A stalled EX instruction stays put, so a bubble enters entry 0.
            valid_reg[0] <= ex_valid && !stall;
            we_reg[0]    <= ex_we;
            load_reg[0]  <= ex_is_load;
            rd_reg[0]    <= ex_rd;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                we_reg[i]    <= we_reg[i-1];
                load_reg[i]  <= load_reg[i-1];
                rd_reg[i]    <= rd_reg[i-1];
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: a default-depth instance plus a DEPTH=3 instance on shared stimulus.
module tb_forward_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_is_load;
    logic       flush;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       stall;
    logic [1:0] fwd_rs3;
    logic [1:0] fwd_rt3;
    logic       stall3;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_scoreboard dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .flush(flush),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .stall(stall)
    );

    forward_scoreboard #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(1)) dut3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .flush(flush),
        .fwd_rs(fwd_rs3), .fwd_rt(fwd_rt3),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt(stall_cnt3),
`endif
        .stall(stall3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one EX cycle of inputs after the falling edge; outputs are then checked before the next rising edge.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic we, input logic ld, input logic fl, input logic r);
        @(negedge clk);
        ex_valid = v; ex_rs = rs; ex_rt = rt; ex_rd = rd;
        ex_we = we; ex_is_load = ld; flush = fl; rst = r;
        #1;
        $display("step v=%0b rs=%0d rt=%0d rd=%0d we=%0b ld=%0b fl=%0b rst=%0b -> fwd_rs=%0d fwd_rt=%0d stall=%0b | d3 fwd_rs=%0d fwd_rt=%0d stall=%0b",
                 v, rs, rt, rd, we, ld, fl, r, fwd_rs, fwd_rt, stall, fwd_rs3, fwd_rt3, stall3);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_we = 1'b0; ex_is_load = 1'b0; flush = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset state: nothing tracked yet
        step(1, 5, 6, 0, 0, 0, 0, 0);
        chk("reset_fwd_rs", 32'(fwd_rs), 0);
        chk("reset_fwd_rt", 32'(fwd_rt), 0);
        chk("reset_stall", 32'(stall), 0);
`ifdef FWD_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif

        // Back-to-back add $2 chain
        step(1, 2, 0, 2, 1, 0, 0, 0);
        chk("add2_first_fwd_rs", 32'(fwd_rs), 0);
        step(1, 2, 0, 2, 1, 0, 0, 0);
        chk("add2_second_fwd_rs", 32'(fwd_rs), 1);
        chk("add2_second_stall", 32'(stall), 0);
        step(1, 2, 0, 2, 1, 0, 0, 0);
        chk("add2_third_fwd_rs", 32'(fwd_rs), 1);
        chk("add2_third_stall", 32'(stall), 0);

        // ex_valid=0 forces all outputs to zero despite a live match
        step(0, 2, 2, 0, 0, 0, 0, 0);
        chk("nop_fwd_rs", 32'(fwd_rs), 0);
        chk("nop_fwd_rt", 32'(fwd_rt), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // add $3, nop, consumer rt=3
        step(1, 0, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0);
        chk("add3_1nop_fwd_rt", 32'(fwd_rt), 2);
        chk("add3_1nop_d3_fwd_rt", 32'(fwd_rt3), 2);

        // add $3, two nops, consumer rt=3: only the deeper instance still tracks it
        step(1, 0, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0, 0, 0);
        chk("add3_2nop_d3_fwd_rt", 32'(fwd_rt3), 3);
        chk("add3_2nop_dropped_fwd_rt", 32'(fwd_rt), 0);

        // lw $4 then consumer rs=4: one stall cycle, then forward from WB
        step(1, 0, 0, 4, 1, 1, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0, 0);
        chk("lw4_stall", 32'(stall), 1);
        chk("lw4_stall_fwd_rs", 32'(fwd_rs), 1);
        step(1, 4, 0, 0, 0, 0, 0, 0);
        chk("lw4_after_stall", 32'(stall), 0);
        chk("lw4_after_fwd_rs", 32'(fwd_rs), 2);
`ifdef FWD_STALL_CNT_EN
        chk("lw4_stall_cnt", stall_cnt, 1);
`endif

        // Writing $0 is never forwarded
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reg0_fwd_rs", 32'(fwd_rs), 0);
        chk("reg0_fwd_rt", 32'(fwd_rt), 0);

        // Flush: outputs unaffected in the flush cycle, cleared afterwards
        step(1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 1, 0);
        chk("flush_cycle_fwd_rs", 32'(fwd_rs), 1);
        step(1, 5, 6, 0, 0, 0, 0, 0);
        chk("post_flush_fwd_rs", 32'(fwd_rs), 0);
        chk("post_flush_fwd_rt", 32'(fwd_rt), 0);

        // Reset during a load-use stall
        step(1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 1);
        chk("rst_stall_before", 32'(stall), 1);
        step(1, 7, 0, 0, 0, 0, 0, 0);
        chk("rst_stall_after", 32'(stall), 0);
        chk("rst_fwd_rs_after", 32'(fwd_rs), 0);
`ifdef FWD_STALL_CNT_EN
        chk("rst_stall_cnt_after", stall_cnt, 0);
`endif

        // Load-use through rt also stalls
        step(1, 0, 0, 8, 1, 1, 0, 0);
        step(1, 0, 8, 0, 0, 0, 0, 0);
        chk("lw8_rt_stall", 32'(stall), 1);
        chk("lw8_rt_fwd_rt", 32'(fwd_rt), 1);
        step(1, 0, 8, 0, 0, 0, 0, 0);
        chk("lw8_rt_after_stall", 32'(stall), 0);
        chk("lw8_rt_after_fwd_rt", 32'(fwd_rt), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
